// File: rtl/serial_compare_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// serial_compare_ctrl_pkg
// Shared definitions for the serial magnitude comparator:
//   state_t      - sequencer states (IDLE, COMPARE)
//   SLICE_W      - number of operand bits examined per clock
//   steps_width  - width of the steps counter for a given operand width
// ----------------------------------------------------------------------------
package serial_compare_ctrl_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        COMPARE = 1'b1
    } state_t;

    localparam int SLICE_W = 2;

    // The counter must be able to hold NSLICE itself, hence the +1.
    function automatic int steps_width(input int width);
        return $clog2(width / SLICE_W) + 1;
    endfunction

endpackage

// File: rtl/greater_than_2.sv
// ----------------------------------------------------------------------------
// greater_than_2
// Unsigned 2-bit magnitude comparator.
//   a, b : 2-bit unsigned operands
//   gt   : 1 when a > b
// ----------------------------------------------------------------------------
module greater_than_2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       gt
);

    // MSB decides unless the MSBs match, then the LSB decides.
    assign gt = (a[1] & ~b[1]) | ((a[1] ~^ b[1]) & a[0] & ~b[0]);

endmodule

// File: rtl/serial_compare_ctrl.sv
// ----------------------------------------------------------------------------
// serial_compare_ctrl
// Compares two unsigned WIDTH-bit operands two bits per clock, MSB slice
// first, stopping at the first slice that differs.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   start  : request, accepted only while ready=1
//   a, b   : operands, captured at the accept edge
//   ready  : idle, start will be accepted
//   done   : one-cycle pulse, result valid
//   gt/eq/lt : one-hot result, held until the next accept
//   steps  : number of slices evaluated for the last result
// ----------------------------------------------------------------------------
module serial_compare_ctrl
    import serial_compare_ctrl_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int SW    = steps_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt,
    output logic [SW-1:0]    steps
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IW-1:0] IDX_TOP = IW'(NSLICE - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q, a_nxt, b_nxt;
    logic [IW-1:0]    idx, idx_nxt;
    logic [SW-1:0]    steps_nxt;
    logic             done_nxt, gt_nxt, eq_nxt, lt_nxt;
    logic [1:0]       sa, sb;
    logic             g, l;

    // Slice select: a compare over all slice positions keeps every part
    // select constant, which also covers the single-slice WIDTH=2 case.
    always_comb begin
        sa = '0;
        sb = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx == IW'(i)) begin
                sa = a_q[SLICE_W*i +: SLICE_W];
                sb = b_q[SLICE_W*i +: SLICE_W];
            end
        end
    end

    // Same comparator both ways round gives greater and less; equal when
    // neither fires.
    greater_than_2 u_gt_ab (
        .a  (sa),
        .b  (sb),
        .gt (g)
    );

    greater_than_2 u_gt_ba (
        .a  (sb),
        .b  (sa),
        .gt (l)
    );

    assign ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            idx   <= '0;
            steps <= '0;
            done  <= 1'b0;
            gt    <= 1'b0;
            eq    <= 1'b0;
            lt    <= 1'b0;
        end else begin
            state <= state_nxt;
            a_q   <= a_nxt;
            b_q   <= b_nxt;
            idx   <= idx_nxt;
            steps <= steps_nxt;
            done  <= done_nxt;
            gt    <= gt_nxt;
            eq    <= eq_nxt;
            lt    <= lt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        a_nxt     = a_q;
        b_nxt     = b_q;
        idx_nxt   = idx;
        steps_nxt = steps;
        done_nxt  = 1'b0;
        gt_nxt    = gt;
        eq_nxt    = eq;
        lt_nxt    = lt;

        case (state)
            IDLE: begin
                // Also taken during the done cycle, giving back-to-back runs.
                if (start) begin
                    state_nxt = COMPARE;
                    a_nxt     = a;
                    b_nxt     = b;
                    idx_nxt   = IDX_TOP;
                    steps_nxt = '0;
                    gt_nxt    = 1'b0;
                    eq_nxt    = 1'b0;
                    lt_nxt    = 1'b0;
                end
            end
            COMPARE: begin
                steps_nxt = steps + SW'(1);
                if (g) begin
                    gt_nxt    = 1'b1;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else if (l) begin
                    lt_nxt    = 1'b1;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else if (idx == '0) begin
                    eq_nxt    = 1'b1;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    idx_nxt   = idx - IW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_serial_compare_ctrl.sv
`timescale 1ns/1ps
module tb_serial_compare_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       ready, done, gt, eq, lt;
    logic [2:0] steps;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic       ready4, done4, gt4, eq4, lt4;
    logic [1:0] steps4;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    serial_compare_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .ready (ready),
        .done  (done),
        .gt    (gt),
        .eq    (eq),
        .lt    (lt),
        .steps (steps)
    );

    serial_compare_ctrl #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .ready (ready4),
        .done  (done4),
        .gt    (gt4),
        .eq    (eq4),
        .lt    (lt4),
        .steps (steps4)
    );

    // The two comparator outputs must never both be high.
    always @(posedge clk) begin
        if (rst_n && (dut.g && dut.l)) begin
            fails++;
            $display("FAIL g_l_exclusive8 g=%0b l=%0b required not both 1", dut.g, dut.l);
        end
        if (rst_n && (dut4.g && dut4.l)) begin
            fails++;
            $display("FAIL g_l_exclusive4 g=%0b l=%0b required not both 1", dut4.g, dut4.l);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Starts an 8-bit operation at posedge+1 and returns the number of edges
    // after the accept edge until done is seen (-1 if it never appears).
    task automatic do_op(input logic [7:0] av, input logic [7:0] bv, output int lat);
        start = 1'b1;
        a = av;
        b = bv;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        a = 8'hFF;
        b = 8'h00;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            tests++;
            if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", ready); end
            tests++;
            if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
            tests++;
            if ({gt, eq, lt} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b want 000", {gt, eq, lt}); end
            tests++;
            if (steps !== 3'd0) begin fails++; $display("FAIL reset_steps got %0d want 0", steps); end
        end
        start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_compare();
        int lat;
        do_op(8'hC0, 8'h40, lat);
        tests++;
        if (lat !== 1) begin fails++; $display("FAIL c0_40_latency got %0d want 1", lat); end
        tests++;
        if ({gt, eq, lt} !== 3'b100) begin fails++; $display("FAIL c0_40_flags got %b want 100", {gt, eq, lt}); end
        tests++;
        if (steps !== 3'd1) begin fails++; $display("FAIL c0_40_steps got %0d want 1", steps); end
        tests++;
        if (ready !== 1'b1) begin fails++; $display("FAIL c0_40_ready got %b want 1", ready); end
        @(posedge clk); #1;
        tests++;
        if (done !== 1'b0) begin fails++; $display("FAIL c0_40_done_pulse got %b want 0", done); end
        tests++;
        if ({gt, eq, lt, steps} !== {3'b100, 3'd1}) begin
            fails++; $display("FAIL c0_40_hold got %b/%0d want 100/1", {gt, eq, lt}, steps);
        end

        do_op(8'h12, 8'h13, lat);
        tests++;
        if (lat !== 4) begin fails++; $display("FAIL 12_13_latency got %0d want 4", lat); end
        tests++;
        if ({gt, eq, lt} !== 3'b001) begin fails++; $display("FAIL 12_13_flags got %b want 001", {gt, eq, lt}); end
        tests++;
        if (steps !== 3'd4) begin fails++; $display("FAIL 12_13_steps got %0d want 4", steps); end
        @(posedge clk); #1;

        do_op(8'hA5, 8'hA5, lat);
        tests++;
        if (lat !== 4) begin fails++; $display("FAIL a5_a5_latency got %0d want 4", lat); end
        tests++;
        if ({gt, eq, lt} !== 3'b010) begin fails++; $display("FAIL a5_a5_flags got %b want 010", {gt, eq, lt}); end
        tests++;
        if (steps !== 3'd4) begin fails++; $display("FAIL a5_a5_steps got %0d want 4", steps); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int lat;
        start = 1'b1;
        a = 8'h00;
        b = 8'h80;
        @(posedge clk); #1;
        // Busy: this request and these operands must be ignored.
        a = 8'hFF;
        b = 8'h00;
        @(posedge clk); #1;
        tests++;
        if (done !== 1'b1) begin fails++; $display("FAIL ignore_done got %b want 1", done); end
        tests++;
        if ({gt, eq, lt} !== 3'b001) begin fails++; $display("FAIL ignore_flags got %b want 001", {gt, eq, lt}); end
        tests++;
        if (steps !== 3'd1) begin fails++; $display("FAIL ignore_steps got %0d want 1", steps); end
        // start still high during the done cycle: accepted.
        a = 8'h30;
        b = 8'h20;
        @(posedge clk); #1;
        start = 1'b0;
        tests++;
        if (done !== 1'b0) begin fails++; $display("FAIL b2b_done_drop got %b want 0", done); end
        tests++;
        if ({gt, eq, lt} !== 3'b000) begin fails++; $display("FAIL b2b_clear got %b want 000", {gt, eq, lt}); end
        tests++;
        if (ready !== 1'b0) begin fails++; $display("FAIL b2b_ready got %b want 0", ready); end
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        tests++;
        if (lat !== 2) begin fails++; $display("FAIL b2b_latency got %0d want 2", lat); end
        tests++;
        if ({gt, eq, lt} !== 3'b100) begin fails++; $display("FAIL b2b_flags got %b want 100", {gt, eq, lt}); end
        tests++;
        if (steps !== 3'd2) begin fails++; $display("FAIL b2b_steps got %0d want 2", steps); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort();
        int lat;
        int seen;
        start = 1'b1;
        a = 8'h55;
        b = 8'h56;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        tests++;
        if ({ready, steps} !== {1'b0, 3'd1}) begin
            fails++; $display("FAIL abort_busy got ready=%b steps=%0d want 0/1", ready, steps);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (ready !== 1'b1) begin fails++; $display("FAIL abort_ready got %b want 1", ready); end
        tests++;
        if (steps !== 3'd0) begin fails++; $display("FAIL abort_steps got %0d want 0", steps); end
        tests++;
        if ({done, gt, eq, lt} !== 4'b0000) begin
            fails++; $display("FAIL abort_flags got %b want 0000", {done, gt, eq, lt});
        end
        seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        tests++;
        if (seen !== 0) begin fails++; $display("FAIL abort_no_done got %0d pulses want 0", seen); end

        do_op(8'h55, 8'h56, lat);
        tests++;
        if (lat !== 4) begin fails++; $display("FAIL rerun_latency got %0d want 4", lat); end
        tests++;
        if ({gt, eq, lt} !== 3'b001) begin fails++; $display("FAIL rerun_flags got %b want 001", {gt, eq, lt}); end
        tests++;
        if (steps !== 3'd4) begin fails++; $display("FAIL rerun_steps got %0d want 4", steps); end
        @(posedge clk); #1;
    endtask

    task automatic test_sweep4();
        logic [3:0] av, bv;
        logic [2:0] exp_flags, got_flags;
        logic [1:0] got_steps;
        int exp_p, cnt, first;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                av = 4'(i);
                bv = 4'(j);
                exp_flags = (i > j) ? 3'b100 : ((i == j) ? 3'b010 : 3'b001);
                exp_p = (av[3:2] != bv[3:2]) ? 1 : 2;
                start4 = 1'b1;
                a4 = av;
                b4 = bv;
                @(posedge clk); #1;
                start4 = 1'b0;
                cnt = 0;
                first = -1;
                got_flags = 3'b000;
                got_steps = 2'd0;
                for (int k = 1; k <= 4; k++) begin
                    @(posedge clk); #1;
                    if (done4) begin
                        cnt++;
                        if (first < 0) begin
                            first = k;
                            got_flags = {gt4, eq4, lt4};
                            got_steps = steps4;
                        end
                    end
                end
                tests++;
                if (cnt !== 1) begin fails++; $display("FAIL sweep_done_count a=%h b=%h got %0d want 1", av, bv, cnt); end
                tests++;
                if (got_flags !== exp_flags) begin
                    fails++; $display("FAIL sweep_flags a=%h b=%h got %b want %b", av, bv, got_flags, exp_flags);
                end
                tests++;
                if (got_steps !== 2'(exp_p)) begin
                    fails++; $display("FAIL sweep_steps a=%h b=%h got %0d want %0d", av, bv, got_steps, exp_p);
                end
                tests++;
                if (first !== exp_p) begin
                    fails++; $display("FAIL sweep_latency a=%h b=%h got %0d want %0d", av, bv, first, exp_p);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_compare();
        test_back_to_back();
        test_reset_abort();
        test_sweep4();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_compare_ctrl.md
Name: serial_compare_ctrl

Overview:
Sequencer that compares two WIDTH-bit unsigned operands by walking them 2 bits at a time, MSB slice first. Each slice goes through the team's 2-bit greater-than comparator. The block stops early at the first slice that differs. It sits in front of the 2-bit comparator datapath, owns operand capture and slice scheduling, and returns a one-hot gt/eq/lt result with a start/done handshake.

Parameters:
WIDTH, 8, operand width in bits; must be even and >= 2; NSLICE = WIDTH/2
SW, $clog2(WIDTH/2)+1, width of the steps output (derived, not overridden)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
start  in  1  request; accepted only on an edge where ready=1
a  in  WIDTH  operand A, sampled at the accept edge only
b  in  WIDTH  operand B, sampled at the accept edge only
ready  out  1  idle, can accept start
done  out  1  one-cycle pulse: result valid
gt  out  1  A > B
eq  out  1  A == B
lt  out  1  A < B
steps  out  SW  slices evaluated for the last result (1..NSLICE)

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, ready=1, done=0, gt=eq=lt=0, steps=0, operand registers 0, slice index 0.
- States: IDLE, COMPARE.
- IDLE -> COMPARE on an edge with start=1:
  - register a and b;
  - set idx=NSLICE-1 and steps=0;
  - clear gt/eq/lt;
  - ready=0 from the next cycle.
- COMPARE, one slice per clock:
  - sa=A[2*idx+1:2*idx], sb=B[2*idx+1:2*idx];
  - g=greater_than_2(sa,sb), l=greater_than_2(sb,sa);
  - steps increments each COMPARE edge.
- Termination, evaluated at each COMPARE edge:
  - g=1: gt=1, go to IDLE;
  - l=1: lt=1, go to IDLE;
  - g=l=0 and idx==0: eq=1, go to IDLE;
  - otherwise idx decrements and the block stays in COMPARE.
- At the terminating edge: done=1 and ready=1 for exactly the following cycle. done then returns to 0.
- gt/eq/lt/steps hold until the next accept edge. Exactly one of gt/eq/lt is 1 after any completed operation.
- Latency: if the first differing slice is the p-th from the MSB (1-based), done is high in the cycle p edges after the accept edge and steps=p. For equal operands, p=NSLICE.
- start while ready=0 is ignored. a/b changes while busy have no effect.
- start during the done cycle is accepted (back-to-back). The new operation clears gt/eq/lt at that edge, and done drops.
- WIDTH=2: single COMPARE cycle, steps=1.
- rst_n asserted mid-COMPARE: immediately returns to the reset values. No done is produced for the aborted operation.
- g and l are never both 1. The bench asserts this.

Decomposition:
- Shared package: state enum {IDLE, COMPARE}; SLICE_W=2 constant; steps-width helper function.
- Sub-module: greater_than_2, the existing 2-bit comparator, instantiated twice (a-vs-b and b-vs-a) on the selected slice. Slice mux and FSM stay in serial_compare_ctrl.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with start=1 -> ready=1, done=0, gt=eq=lt=0, steps=0 throughout.
- WIDTH=8, a=8'hC0, b=8'h40, start one cycle -> done high 1 cycle after accept; gt=1, eq=0, lt=0, steps=1.
- a=8'h12, b=8'h13 -> done 4 cycles after accept; lt=1, steps=4. a=8'hA5, b=8'hA5 -> done after 4 cycles; eq=1, steps=4.
- Accept a=8'h00/b=8'h80. One cycle later, drive start=1 with a=8'hFF, b=8'h00 -> second start ignored; result lt=1, steps=1. Then start during the done cycle with a=8'h30, b=8'h20 -> accepted; gt=1, steps=2.
- Accept a=8'h55, b=8'h56, then pull rst_n low during the 2nd COMPARE cycle -> outputs go to reset values asynchronously, no done pulse. Release reset and rerun a=8'h55, b=8'h56 -> lt=1, steps=4.
- Exhaustive WIDTH=4 sweep of all 256 a/b pairs -> gt/eq/lt match the golden model; steps equals the index of the first differing slice (2 if equal); done appears exactly once per start.
